fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised next-generation fetch stage. It generates sequential PCs and
//  issues them on a valid/ready instruction-memory request channel. In-order
//  responses are buffered with their PC in a DEPTH-entry queue and handed to
//  decode on a valid/ready port. A branch redirect flushes the queue and
//  discards stale in-flight responses. Sits between imem and decode.
// PARAMETERS
//  XLEN      32  PC/address width
//  ILEN      32  instruction word width
//  DEPTH     4   queue entries = max (queued + in-flight); power of 2, >=2
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk              in   1     clock
//  rst              in   1     reset, asynchronous, active-high
//  imem_req_valid_o out  1     fetch request valid
//  imem_req_ready_i in   1     imem accepts request
//  imem_req_addr_o  out  XLEN  fetch address
//  imem_rsp_valid_i in   1     response valid; in order, no backpressure
//  imem_rsp_data_i  in   ILEN  instruction word
//  valid_o          out  1     queue head valid to decode
//  ready_i          in   1     decode accepts head
//  pc_o             out  XLEN  PC of head entry
//  instr_o          out  ILEN  instruction of head entry
//  branch_taken_i   in   1     redirect strobe
//  branch_addr_i    in   XLEN  redirect target
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, inflight N=0, discard D=0.
//    valid_o=0, imem_req_valid_o=0, pc_o/instr_o=0 while rst high.
//  - Request: imem_req_valid_o = !branch_taken_i && (count + N - D) < DEPTH.
//    imem_req_addr_o = fetch_pc. On accept, fetch_pc += 4 and N += 1.
//    Valid and addr are held until accepted, except on a redirect cycle,
//    where the request is withdrawn. imem must tolerate withdrawal.
//  - Response: N -= 1. If D>0, the word is dropped and D -= 1. Otherwise
//    {pc, instr} is pushed, with pc taken from a per-request PC FIFO
//    (DEPTH deep). The credit rule guarantees the queue never overflows.
//  - Output: valid_o = count!=0. Pop on valid_o && ready_i.
//    A push into an empty queue is visible the next cycle (1-cycle rsp->decode).
//  - Simultaneous push and pop at full or at empty is legal. Count is unchanged.
//  - Redirect (branch_taken_i=1), all same cycle:
//    * Queue cleared; a pop or push in this cycle is ignored.
//    * fetch_pc <= branch_addr_i; D <= N - imem_rsp_valid_i.
//    * The first request to the target issues the next cycle.
//    * valid_o is 0 the next cycle.
//  - Back-to-back redirects: the last one wins, and D is recomputed each time.
//  - fetch_pc wraps modulo 2^XLEN. branch_addr_i[1:0] is forced to 0.
//  - Counters N, D, count are $clog2(DEPTH+1) bits. N never exceeds DEPTH.
//  - Reset asserted mid-operation: all state is cleared immediately.
//    Late responses after reset release are a system error, not handled here.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds perf_stall_o (32, cycles with
//    req_valid && !req_ready), perf_flush_o (32, redirects) and
//    perf_drop_o (32, discarded responses). All reset to 0 and saturate.
//  FETCH_PERF_EN undefined: these ports and counters are absent.
//    Behaviour is otherwise identical.
// STRUCTURE
//  - rv_pkg: XLEN/ILEN defaults, typedef fetch_entry_t {pc, instr},
//    localparam INSTR_BYTES=4.
//  - Sub-module fetch_fifo: sync FIFO with flush input. Instantiated twice:
//    the entry queue (fetch_entry_t) and the in-flight PC FIFO (XLEN).
//  - Top level holds fetch_pc, N, D, credit logic and redirect control.
// TESTING
//  1 Reset, req_ready=1, rsp 1 cycle later, ready_i=1 -> decode sees
//    pc 0,4,8,... back to back, one per cycle.
//  2 ready_i=0, DEPTH=4 -> exactly 4 requests accepted, then
//    req_valid_o=0. ready_i=1 -> pcs 0..12 drain in order.
//  3 req_ready=0 for 5 cycles -> addr stable at 0x0. Ready rises ->
//    accepted once, no duplicate.
//  4 Redirect to 0x100 with 2 in flight -> the next 2 responses are dropped;
//    first valid_o shows pc 0x100.
//  5 Redirect on the same cycle as a response and a pop -> D=N-1, queue
//    empty, no stale pc is ever emitted.
//  6 Two redirects in consecutive cycles (0x200, then 0x300) -> decode sees
//    0x300 first. FETCH_PERF_EN: perf_flush_o=2.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch stage.
// Optional build macro used by this slice: FETCH_PERF_EN (performance counters).
package fetch_queue_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ILEN_DEF    = 32;
    localparam int INSTR_BYTES = 4;

    // One decoded-side queue entry: the fetch PC and the word returned for it.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

    // Saturating 32-bit increment for event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        logic [31:0] result;
        if (en && (value != 32'hFFFF_FFFF)) begin
            result = value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with a flush input that empties it in one cycle.
// A flush takes priority over any push or pop in the same cycle.
// data_o reads zero while the FIFO is empty so stale contents never leak out.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    // A pop needs data; a push needs room, which a simultaneous pop provides.
    always_comb begin
        pop_s  = pop_i && (count_r != '0);
        push_s = push_i && ((count_r != FULL_C) || pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are qualified by count_r so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_s && !flush_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Head read, forced to zero when nothing is held.
    always_comb begin
        if (count_r != '0) begin
            data_o = mem_r[rd_ptr_r];
        end else begin
            data_o = '0;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response buffering toward decode, and branch redirect flushing.
// Optional build macro: FETCH_PERF_EN adds saturating perf counters
// perf_stall_o, perf_flush_o and perf_drop_o.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               ILEN     = ILEN_DEF,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_addr_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_o,
    output logic [31:0]     perf_flush_o,
    output logic [31:0]     perf_drop_o
`endif
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0]      fetch_pc_r;
    logic [CW-1:0]        discard_r;
    logic [CW-1:0]        count_s;
    logic [CW-1:0]        inflight_s;
    logic [CW:0]          used_s;
    logic                 req_valid_s;
    logic                 req_fire_s;
    logic                 push_s;
    logic                 pop_s;
    logic [XLEN-1:0]      target_s;
    logic [XLEN-1:0]      rsp_pc_s;
    logic [XLEN+ILEN-1:0] head_s;

    // Credit check: queued entries plus live (non-discarded) requests must stay
    // below DEPTH. The in-flight PC FIFO also tracks discarded requests, so the
    // total in flight is capped at DEPTH as well to keep that FIFO from overflowing.
    always_comb begin
        used_s      = {1'b0, count_s} + {1'b0, inflight_s} - {1'b0, discard_r};
        req_valid_s = !rst && !branch_taken_i
                      && (used_s < {1'b0, DEPTH_C})
                      && (inflight_s < DEPTH_C);
        req_fire_s  = req_valid_s && imem_req_ready_i;
        push_s      = imem_rsp_valid_i && (discard_r == '0);
        pop_s       = valid_o && ready_i;
        target_s    = branch_addr_i & ~XLEN'(3);
    end

    // Next fetch address: redirect wins, otherwise advance on each accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (branch_taken_i) begin
            fetch_pc_r <= target_s;
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(INSTR_BYTES);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Number of responses still to arrive that belong to a flushed path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard_r <= '0;
        end else if (branch_taken_i) begin
            discard_r <= inflight_s - CW'(imem_rsp_valid_i);
        end else if (imem_rsp_valid_i && (discard_r != '0)) begin
            discard_r <= discard_r - CW'(1);
        end else begin
            discard_r <= discard_r;
        end
    end

    // PCs of outstanding requests, popped by every response (kept or dropped);
    // its occupancy is the in-flight count.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (req_fire_s),
        .data_i  (fetch_pc_r),
        .pop_i   (imem_rsp_valid_i),
        .data_o  (rsp_pc_s),
        .count_o (inflight_s)
    );

    // Entry queue toward decode; a redirect empties it and ignores that cycle's push/pop.
    fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_taken_i),
        .push_i  (push_s),
        .data_i  ({rsp_pc_s, imem_rsp_data_i}),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .count_o (count_s)
    );

    assign imem_req_valid_o = req_valid_s;
    assign imem_req_addr_o  = fetch_pc_r;
    assign valid_o          = (count_s != '0);
    assign pc_o             = head_s[XLEN+ILEN-1:ILEN];
    assign instr_o          = head_s[ILEN-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;
    logic [31:0] perf_drop_r;

    // Saturating event counters: stalled requests, redirects, dropped responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
            perf_drop_r  <= 32'd0;
        end else begin
            perf_stall_r <= sat_inc32(perf_stall_r, req_valid_s && !imem_req_ready_i);
            perf_flush_r <= sat_inc32(perf_flush_r, branch_taken_i);
            perf_drop_r  <= sat_inc32(perf_drop_r,
                                      imem_rsp_valid_i && ((discard_r != '0) || branch_taken_i));
        end
    end

    assign perf_stall_o = perf_stall_r;
    assign perf_flush_o = perf_flush_r;
    assign perf_drop_o  = perf_drop_r;
`endif

endmodule
